// File: rtl/pgr_apb_arb_2m.sv
// -----------------------------------------------------------------------------
// pgr_apb_arb_2m
//
// Two-master round-robin arbiter for the shared register bus used by the
// UART-to-register control path. One transaction is in flight at a time. The
// arbiter runs the setup/access phases itself and returns read data plus a
// one-cycle completion strobe to the master that won.
//
// Optional feature macro: PGR_APB_ARB_TIMEOUT_EN
//   defined   : access-phase watchdog aborts after TIMEOUT cycles, sets mN_err
//   undefined : ACCESS waits on p_rdy indefinitely, mN_err tied to 0
//
// Parameters
//   AW       address width
//   DW       data width
//   TIMEOUT  access-phase cycles before abort (>=2, watchdog builds only)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   mN_ce               request, held until mN_rdy
//   mN_addr/wdata/we    request attributes, stable while mN_ce=1
//   mN_rdy              one-cycle completion strobe
//   mN_rdata            read data, held until the next completion to mN
//   mN_err              watchdog abort flag, valid with mN_rdy
//   p_ce/p_enable/p_we  slave bus controls
//   p_addr/p_wdata      slave address / write data
//   p_rdy/p_rdata       slave ready / read data
//   busy                high whenever the FSM is not IDLE
//   gnt                 one-hot owner, 00 when idle
// -----------------------------------------------------------------------------
module pgr_apb_arb_2m #(
    parameter int AW      = 24,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_ce,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_we,
    output logic          m0_rdy,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_ce,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_we,
    output logic          m1_rdy,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          p_ce,
    output logic          p_enable,
    output logic          p_we,
    output logic [AW-1:0] p_addr,
    output logic [DW-1:0] p_wdata,
    input  logic          p_rdy,
    input  logic [DW-1:0] p_rdata,
    output logic          busy,
    output logic [1:0]    gnt
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic          w_start;
    logic          w_win;
    logic          w_cpl;
    logic          w_toHit;
    logic          w_ceNext;
    logic          w_enNext;
    logic          w_respNext;
    logic          w_abort;
    logic          w_load;

    logic          r_owner;
    logic          r_lastGnt;
    logic          r_cpl;
    logic [DW-1:0] r_capData;
    logic          r_pCe;
    logic          r_pEnable;
    logic          r_pWe;
    logic [AW-1:0] r_pAddr;
    logic [DW-1:0] r_pWdata;
    logic          r_m0Rdy;
    logic          r_m1Rdy;
    logic [DW-1:0] r_m0Rdata;
    logic [DW-1:0] r_m1Rdata;
    logic          r_busy;
    logic [1:0]    r_gnt;

`ifdef PGR_APB_ARB_TIMEOUT_EN
    localparam int              CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_toCnt;
    logic             r_capErr;
    logic             r_m0Err;
    logic             r_m1Err;

    // Watchdog: restarts when ACCESS is entered and counts every access
    // cycle in which the slave has not answered yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_toCnt <= '0;
        end else if (r_state == SETUP) begin
            r_toCnt <= '0;
        end else if (r_state == ACCESS && !r_cpl && !p_rdy) begin
            r_toCnt <= r_toCnt + 1'b1;
        end
    end

    assign w_abort = r_capErr;
    assign m0_err  = r_m0Err;
    assign m1_err  = r_m1Err;
`else
    assign w_abort = 1'b0;
    assign m0_err  = 1'b0;
    assign m1_err  = 1'b0;
`endif

    // Next-state and next-output decode. ACCESS spends one extra cycle
    // (r_cpl) after the slave answers, with the bus already released, so
    // the completion strobe and read data come out of registers.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_win       = r_owner;
        w_cpl       = 1'b0;
        w_toHit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0_ce || m1_ce) begin
                    w_start     = 1'b1;
                    w_win       = (m0_ce && m1_ce) ? ~r_lastGnt : m1_ce;
                    w_nextState = SETUP;
                end
            end
            SETUP: begin
                w_nextState = ACCESS;
            end
            ACCESS: begin
                if (r_cpl) begin
                    w_nextState = RESP;
                end else if (p_rdy) begin
                    w_cpl = 1'b1;
                end
`ifdef PGR_APB_ARB_TIMEOUT_EN
                else if (r_toCnt == CNT_MAX) begin
                    w_toHit = 1'b1;
                end
`endif
            end
            RESP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        w_enNext   = (w_nextState == ACCESS) && !w_cpl && !w_toHit;
        w_ceNext   = (w_nextState == SETUP) || w_enNext;
        w_respNext = (r_state == ACCESS) && r_cpl;
        w_load     = w_respNext && (!r_pWe || w_abort);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Registered outputs and transaction context. The p_* attributes are
    // latched only when a new winner is chosen, so they stay put from
    // SETUP through RESP and beyond.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= 1'b0;
            r_lastGnt <= 1'b1;
            r_cpl     <= 1'b0;
            r_capData <= '0;
            r_pCe     <= 1'b0;
            r_pEnable <= 1'b0;
            r_pWe     <= 1'b0;
            r_pAddr   <= '0;
            r_pWdata  <= '0;
            r_m0Rdy   <= 1'b0;
            r_m1Rdy   <= 1'b0;
            r_m0Rdata <= '0;
            r_m1Rdata <= '0;
            r_busy    <= 1'b0;
            r_gnt     <= 2'b00;
`ifdef PGR_APB_ARB_TIMEOUT_EN
            r_capErr  <= 1'b0;
            r_m0Err   <= 1'b0;
            r_m1Err   <= 1'b0;
`endif
        end else begin
            r_pCe     <= w_ceNext;
            r_pEnable <= w_enNext;
            r_busy    <= (w_nextState != IDLE);
            r_gnt     <= (w_nextState == IDLE) ? 2'b00 : (w_win ? 2'b10 : 2'b01);
            r_cpl     <= w_cpl || w_toHit;
            r_m0Rdy   <= w_respNext && !r_owner;
            r_m1Rdy   <= w_respNext && r_owner;
            if (w_start) begin
                r_owner  <= w_win;
                r_pAddr  <= w_win ? m1_addr  : m0_addr;
                r_pWdata <= w_win ? m1_wdata : m0_wdata;
                r_pWe    <= w_win ? m1_we    : m0_we;
            end
            if (w_cpl) begin
                r_capData <= p_rdata;
            end else if (w_toHit) begin
                r_capData <= '0;
            end
            if (w_load && !r_owner) begin
                r_m0Rdata <= r_capData;
            end
            if (w_load && r_owner) begin
                r_m1Rdata <= r_capData;
            end
            if (r_state == RESP) begin
                r_lastGnt <= r_owner;
            end
`ifdef PGR_APB_ARB_TIMEOUT_EN
            if (w_cpl || w_toHit) begin
                r_capErr <= w_toHit;
            end
            r_m0Err <= w_respNext && !r_owner && r_capErr;
            r_m1Err <= w_respNext && r_owner && r_capErr;
`endif
        end
    end

    assign p_ce     = r_pCe;
    assign p_enable = r_pEnable;
    assign p_we     = r_pWe;
    assign p_addr   = r_pAddr;
    assign p_wdata  = r_pWdata;
    assign m0_rdy   = r_m0Rdy;
    assign m1_rdy   = r_m1Rdy;
    assign m0_rdata = r_m0Rdata;
    assign m1_rdata = r_m1Rdata;
    assign busy     = r_busy;
    assign gnt      = r_gnt;

endmodule

// File: doc/pgr_apb_arb_2m.md
# pgr_apb_arb_2m

Two-master arbiter for the shared register bus (p_ce/p_addr/p_wdata/p_enable/p_we/p_rdy/p_rdata) used by the UART-to-register control path. It lets two requesters share one slave port, for example the UART command controller and an on-chip init sequencer. Arbitration is round-robin and one transaction is in flight at a time. The arbiter drives the setup/access phases itself and returns read data plus a one-cycle completion strobe to the winning master. An optional watchdog aborts transactions whose slave never asserts p_rdy.

## Interface
Parameters:
- AW, 24, address width
- DW, 32, data width
- TIMEOUT, 1024, access-phase cycles before abort (≥2; used only with the watchdog compiled in)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous reset, active-high
- m0_ce, m1_ce  in  1  request; held high until that master's mN_rdy pulse
- m0_addr, m1_addr  in  AW  address, stable while mN_ce=1
- m0_wdata, m1_wdata  in  DW  write data, stable while mN_ce=1
- m0_we, m1_we  in  1  1=write, 0=read, stable while mN_ce=1
- m0_rdy, m1_rdy  out  1  one-cycle completion strobe
- m0_rdata, m1_rdata  out  DW  read data, valid with mN_rdy, held until next completion to that master
- m0_err, m1_err  out  1  timeout flag, valid with mN_rdy
- p_ce, p_enable, p_we  out  1  slave bus controls
- p_addr  out  AW  slave address
- p_wdata  out  DW  slave write data
- p_rdy  in  1  slave ready
- p_rdata  in  DW  slave read data, sampled with p_rdy
- busy  out  1  high in any state other than IDLE
- gnt  out  2  one-hot owner; 00 when idle

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any mN_ce=1, pick a winner and latch its addr/wdata/we into p_* registers, then go to SETUP.
  - Round-robin: on a simultaneous request, grant the master that did not win last. last_grant resets to m1, so m0 wins the first tie.
- SETUP: drive p_ce=1, p_enable=0 for exactly one cycle, then go to ACCESS.
- ACCESS:
  - Drive p_ce=1, p_enable=1.
  - On p_rdy=1, capture p_rdata into the winner's rdata register for reads, and go to RESP.
  - On writes, mN_rdata keeps its previous value.
- RESP:
  - p_ce=0, p_enable=0.
  - Pulse the winner's mN_rdy, update last_grant, go to IDLE.
- Masters must drop mN_ce, or present a new request, on the edge after mN_rdy. IDLE samples requests only after that.
- The loser's request is held pending and wins the next IDLE cycle.
- p_addr, p_wdata and p_we hold their values from SETUP through RESP. They are not cleared on return to IDLE.
- The losing master's outputs never change during another master's transaction.
- Reset mid-transaction:
  - FSM goes to IDLE, all outputs go to their reset values, last_grant=m1.
  - The in-flight transaction is dropped with no mN_rdy.
- Reset values: all 1-bit outputs 0, gnt=00, p_addr=0, p_wdata=0, m0_rdata=m1_rdata=0.

## Timing
- All outputs are registered.
- Request sampled in IDLE at edge n:
  - SETUP visible after edge n+1 (p_ce=1).
  - ACCESS visible after edge n+2 (p_enable=1).
- p_rdy sampled high at edge k in ACCESS: RESP visible after edge k+1, with mN_rdy=1 and rdata valid. IDLE follows after edge k+2.
- Zero-wait slave (p_rdy=1 in the first ACCESS cycle): request to mN_rdy is 4 cycles. Back-to-back transactions are 5 cycles apart.
- p_rdy is ignored outside ACCESS.

## Configuration
- PGR_APB_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT) clears on entering ACCESS and increments each ACCESS cycle without p_rdy.
  - When it reaches TIMEOUT-1 with p_rdy still 0, go to RESP with mN_err=1 and mN_rdata=0.
  - p_rdy arriving in the same cycle as the limit wins: normal completion, err=0.
- PGR_APB_ARB_TIMEOUT_EN undefined:
  - No counter; ACCESS waits on p_rdy indefinitely.
  - m0_err and m1_err are constant 0.

## Test plan
- m0 single read, slave returns 0xA5A5_0001 with zero wait: p_ce rises 1 cycle after request, p_enable 2 cycles after. m0_rdy pulses 4 cycles after request with m0_rdata=0xA5A5_0001, gnt=01.
- m0 and m1 both request on the same cycle, three times in a row: grant order m0, m1, m0, m1, m0, m1. Each loser's request stays pending with no lost transaction.
- m1 write addr=0x00_0010, data=0x1234_5678, slave 3 wait cycles: p_we=1 and p_addr/p_wdata held through ACCESS. m1_rdy arrives 7 cycles after request; m1_rdata unchanged.
- rst asserted in ACCESS: next cycle p_ce=p_enable=busy=0, gnt=00, no mN_rdy. After release, a simultaneous request grants m0 first.
- Timeout, with PGR_APB_ARB_TIMEOUT_EN and TIMEOUT=8, slave never ready: m0_rdy and m0_err=1 with m0_rdata=0 after 8 ACCESS cycles. A follow-up m1 request completes normally.
- Timeout, without PGR_APB_ARB_TIMEOUT_EN, p_rdy delayed 2000 cycles: the transaction completes normally with err=0.
